mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline with a real load/store unit. Sits between the EX/MEM and MEM/WB registers.
//  Drives a req/gnt/rvalid data bus and handles byte/half/word stores (byte enables) and loads (lane select, sign/zero extend).
//  Raises stall_req_o to the pipeline controller while an access is pending. Passes reg-file and HI/LO writeback to WB.
// PARAMETERS
//  DATA_W      32   data bus / register width; 32 or 64 (NB = DATA_W/8 byte lanes)
//  ADDR_W      32   data bus address width
//  REG_ADDR_W  5    register-file address width
//  MAX_WAIT    255  watchdog limit: cycles allowed in REQ+RESP before bus error
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           reset: synchronous, active-high
//  valid_i        in   1           EX/MEM holds a live instruction
//  memop_i        in   4           MEMOP_* code (package)
//  mem_addr_i     in   ADDR_W      effective address
//  store_data_i   in   DATA_W      store source (rt)
//  flush_i        in   1           kill current instruction
//  wreg_i/wd_i/wdata_i  in  1/REG_ADDR_W/DATA_W  reg-file writeback from EX
//  whilo_i/hi_i/lo_i    in  1/DATA_W/DATA_W      HI/LO writeback from EX
//  dbus_req_o     out  1           request valid
//  dbus_we_o      out  1           1 = store
//  dbus_addr_o    out  ADDR_W      word-aligned address (low log2(NB) bits zero)
//  dbus_be_o      out  NB          byte enables
//  dbus_wdata_o   out  DATA_W      lane-replicated store data
//  dbus_gnt_i     in   1           request accepted this cycle
//  dbus_rvalid_i  in   1           read data valid this cycle
//  dbus_rdata_i   in   DATA_W      read data
//  wreg_o/wd_o/wdata_o  out 1/REG_ADDR_W/DATA_W  to MEM/WB
//  whilo_o/hi_o/lo_o    out 1/DATA_W/DATA_W      to MEM/WB
//  stall_req_o    out  1           hold IF..EX/MEM this cycle
//  bus_err_o      out  1           1-cycle pulse: watchdog expiry
//  misalign_o     out  1           1-cycle pulse; present only with MEM_MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset: state IDLE, watchdog 0, every output 0.
//  FSM: IDLE, REQ, RESP, DRAIN, DONE.
//  IDLE, non-mem op or !valid_i: all writeback outputs mirror their inputs combinationally. No stall, no bus activity.
//  IDLE, valid mem op: latch op, addr, data and writeback fields. Set stall_req_o=1 and go to REQ. Outputs forced 0 this cycle.
//  REQ: dbus_req_o=1 with fields from the latched copy; stall=1.
//    On gnt, a store goes to DONE and a load goes to RESP.
//  RESP: stall=1. On rvalid, capture the extracted load result and go to DONE.
//  DONE: stall=0; outputs come from the latched copy. Next state is IDLE; no new access is accepted in DONE.
//    Load: wdata_o = load result. Store: wreg_o forced 0.
//  Best-case stalls: store 2 cycles; load 3 cycles (gnt in the first REQ cycle, rvalid the following cycle).
//  Stores: SB be = 1<<addr[lanes]; SH be = 2'b11<<addr[lanes]; SW be = 4'hF<<addr[lanes]. Data replicated to all lanes.
//  Loads: select lanes from addr; LB/LH sign-extend, LBU/LHU zero-extend, LW sign-extends when DATA_W=64.
//  Watchdog: cleared on entry to REQ and counts each REQ/RESP cycle.
//    At MAX_WAIT: pulse bus_err_o in DONE with wreg_o=0 and go to DONE. A late rvalid after this is ignored in IDLE.
//  flush_i in REQ before gnt: drop the request and go to IDLE.
//  flush_i in RESP: go to DRAIN, wait for rvalid, discard the data, then go to IDLE. No writeback.
//  flush_i in IDLE or DONE: no writeback that cycle.
//  gnt and flush_i in the same cycle: the grant wins; a store completes with no writeback.
//  HI/LO fields are never modified by memop; they are latched and replayed exactly like wreg/wd.
//  rst mid-access: return to IDLE immediately. The bus request is abandoned and no pulses are generated.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: a halfword with addr[0]!=0, or a word with addr[1:0]!=0, makes no bus request.
//    It goes IDLE -> DONE (1 stall cycle), pulses misalign_o, and forces wreg_o=0.
//  MEM_MISALIGN_TRAP_EN undefined: misalign_o port absent. Low address bits are masked (half: addr[0]=0; word: addr[1:0]=0).
// STRUCTURE
//  Shared defines package: MEMOP_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
//    Also the FSM state encodings, RstEnable, WriteDisable, ZeroWord and NOPRegAddr.
//  Sub-module mem_lane_align (combinational): generates be/wdata for stores and performs extract+extend for loads.
// TESTING
//  1 ALU op (wreg=1, wd=5, wdata=0x1234): appears at outputs the same cycle, stall_req_o=0.
//  2 SB addr 0x1003, data 0xAB, gnt immediate: be=4'b1000, wdata=0xABABABAB, 2 stall cycles, wreg_o=0 in DONE.
//  3 LB addr 0x2001, rdata 0x0000_8000, rvalid +1: wdata_o=0xFFFF_FF80 in DONE. LBU gives 0x0000_0080.
//  4 LW with gnt never asserted: bus_err_o pulses after MAX_WAIT cycles, wreg_o=0, FSM returns to IDLE.
//  5 flush_i in RESP, rvalid 2 cycles later: no writeback. The next ALU op passes cleanly.
//  6 With MEM_MISALIGN_TRAP_EN: LH at 0x3001 gives no dbus_req_o and a misalign_o pulse.
//    Without it: access to 0x3000, be=4'b0011.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memop codes, FSM states,
// writeback constants and small memop classification helpers.
package mem_lsu_pkg;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LBU  = 4'd2;
    localparam logic [3:0] MEMOP_LH   = 4'd3;
    localparam logic [3:0] MEMOP_LHU  = 4'd4;
    localparam logic [3:0] MEMOP_LW   = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEMOP_SB) && (op <= MEMOP_SW);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == MEMOP_LW) || (op == MEMOP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store byte enables and lane-replicated data, plus load
// lane extraction with sign/zero extension. Loads also report the lanes they read.
module mem_lane_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int OFF_W  = $clog2(NB)
)(
    input  logic [3:0]        memop,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);
    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        be        = '0;
        wdata     = '0;
        load_data = '0;
        case (memop)
            MEMOP_SB: begin
                be    = NB'(1) << offset;
                wdata = {NB{store_data[7:0]}};
            end
            MEMOP_SH: begin
                be    = NB'(2'b11) << offset;
                wdata = {(NB/2){store_data[15:0]}};
            end
            MEMOP_SW: begin
                be    = NB'(4'hF) << offset;
                wdata = {(NB/4){store_data[31:0]}};
            end
            MEMOP_LB: begin
                be        = NB'(1) << offset;
                load_data = DATA_W'($signed(shifted[7:0]));
            end
            MEMOP_LBU: begin
                be        = NB'(1) << offset;
                load_data = DATA_W'(shifted[7:0]);
            end
            MEMOP_LH: begin
                be        = NB'(2'b11) << offset;
                load_data = DATA_W'($signed(shifted[15:0]));
            end
            MEMOP_LHU: begin
                be        = NB'(2'b11) << offset;
                load_data = DATA_W'(shifted[15:0]);
            end
            MEMOP_LW: begin
                be        = NB'(4'hF) << offset;
                load_data = DATA_W'($signed(shifted[31:0]));
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// MIPS MEM stage with a req/gnt/rvalid load/store unit and writeback pass-through.
// Build macro MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses (adds misalign_o).
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 255
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic                  flush_i,
    input  logic                  wreg_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  whilo_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_W-1:0]     dbus_addr_o,
    output logic [DATA_W/8-1:0]   dbus_be_o,
    output logic [DATA_W-1:0]     dbus_wdata_o,
    input  logic                  dbus_gnt_i,
    input  logic                  dbus_rvalid_i,
    input  logic [DATA_W-1:0]     dbus_rdata_i,
    output logic                  wreg_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stall_req_o,
    output logic                  bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,output logic                  misalign_o
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int WD_W  = $clog2(MAX_WAIT + 1);

    state_e                state, nxt;
    logic [3:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     sdata_q, wdata_q, hi_q, lo_q, load_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q, whilo_q, kill_q, err_q, mis_q;
    logic [WD_W-1:0]       wdog_q;
    logic                  take, expire, mis_in, timeout;
    logic [OFF_W-1:0]      off_in;
    logic [NB-1:0]         be_a;
    logic [DATA_W-1:0]     wdata_a, load_a;

    // Halfword/word offsets are forced to their natural alignment.
    always_comb begin
        off_in = mem_addr_i[OFF_W-1:0];
        if (is_half(memop_i)) off_in[0] = 1'b0;
        if (is_word(memop_i)) off_in[1:0] = 2'b00;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_in     = (is_half(memop_i) && mem_addr_i[0]) ||
                        (is_word(memop_i) && (mem_addr_i[1:0] != 2'b00));
    assign misalign_o = (rst != RstEnable) && (state == S_DONE) && mis_q;
`else
    assign mis_in = 1'b0;
`endif

    assign timeout = (wdog_q == WD_W'(MAX_WAIT - 1));

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .memop      (op_q),
        .offset     (addr_q[OFF_W-1:0]),
        .store_data (sdata_q),
        .rdata      (dbus_rdata_i),
        .be         (be_a),
        .wdata      (wdata_a),
        .load_data  (load_a)
    );

    assign dbus_we_o    = dbus_req_o && is_store(op_q);
    assign dbus_addr_o  = dbus_req_o ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign dbus_be_o    = dbus_req_o ? be_a : '0;
    assign dbus_wdata_o = dbus_req_o ? wdata_a : '0;

    always_comb begin
        nxt         = state;
        take        = 1'b0;
        expire      = 1'b0;
        stall_req_o = 1'b0;
        dbus_req_o  = 1'b0;
        bus_err_o   = 1'b0;
        wreg_o      = WriteDisable;
        wd_o        = '0;
        wdata_o     = '0;
        whilo_o     = WriteDisable;
        hi_o        = '0;
        lo_o        = '0;
        if (rst != RstEnable) begin
            case (state)
                S_IDLE: begin
                    if (valid_i && is_mem(memop_i) && !flush_i) begin
                        take        = 1'b1;
                        stall_req_o = 1'b1;
                        nxt         = mis_in ? S_DONE : S_REQ;
                    end else begin
                        wreg_o  = wreg_i && !flush_i;
                        wd_o    = wd_i;
                        wdata_o = wdata_i;
                        whilo_o = whilo_i && !flush_i;
                        hi_o    = hi_i;
                        lo_o    = lo_i;
                    end
                end
                S_REQ: begin
                    stall_req_o = 1'b1;
                    dbus_req_o  = 1'b1;
                    if (dbus_gnt_i) begin
                        nxt = is_store(op_q) ? S_DONE : (flush_i ? S_DRAIN : S_RESP);
                    end else if (flush_i) begin
                        nxt = S_IDLE;
                    end else if (timeout) begin
                        nxt    = S_DONE;
                        expire = 1'b1;
                    end
                end
                S_RESP: begin
                    stall_req_o = 1'b1;
                    if (flush_i) begin
                        nxt = dbus_rvalid_i ? S_IDLE : S_DRAIN;
                    end else if (dbus_rvalid_i) begin
                        nxt = S_DONE;
                    end else if (timeout) begin
                        nxt    = S_DONE;
                        expire = 1'b1;
                    end
                end
                // Swallow the outstanding read; the watchdog bounds a bus that never answers.
                S_DRAIN: begin
                    stall_req_o = 1'b1;
                    if (dbus_rvalid_i || timeout) nxt = S_IDLE;
                end
                S_DONE: begin
                    nxt       = S_IDLE;
                    bus_err_o = err_q;
                    wreg_o    = wreg_q && !is_store(op_q) && !err_q && !mis_q && !kill_q && !flush_i;
                    wd_o      = wd_q;
                    wdata_o   = is_load(op_q) ? load_q : wdata_q;
                    whilo_o   = whilo_q && !kill_q && !flush_i;
                    hi_o      = hi_q;
                    lo_o      = lo_q;
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state   <= S_IDLE;
            op_q    <= MEMOP_NONE;
            addr_q  <= '0;
            sdata_q <= '0;
            wreg_q  <= 1'b0;
            wd_q    <= '0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            load_q  <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                op_q    <= memop_i;
                addr_q  <= {mem_addr_i[ADDR_W-1:OFF_W], off_in};
                sdata_q <= store_data_i;
                wreg_q  <= wreg_i;
                wd_q    <= wd_i;
                wdata_q <= wdata_i;
                whilo_q <= whilo_i;
                hi_q    <= hi_i;
                lo_q    <= lo_i;
                load_q  <= '0;
                kill_q  <= 1'b0;
                err_q   <= 1'b0;
                mis_q   <= mis_in;
                wdog_q  <= '0;
            end else if ((state == S_REQ) || (state == S_RESP) || (state == S_DRAIN)) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
            // A flush that races the grant still lets a store complete, but without writeback.
            if ((state == S_REQ) && flush_i) kill_q <= 1'b1;
            if (expire) err_q <= 1'b1;
            if ((state == S_RESP) && dbus_rvalid_i && !flush_i) load_q <= load_a;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table-driven ALU pass-through and load/store vectors
// followed by hand-written watchdog, flush, grant/flush race and reset sequences.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int MW = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, flush_i, wreg_i, whilo_i;
    logic [3:0]    memop_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] store_data_i, wdata_i, hi_i, lo_i;
    logic [RW-1:0] wd_i;
    logic          dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i;
    logic [AW-1:0] dbus_addr_o;
    logic [3:0]    dbus_be_o;
    logic [DW-1:0] dbus_wdata_o, dbus_rdata_i;
    logic          wreg_o, whilo_o, stall_req_o, bus_err_o;
    logic [RW-1:0] wd_o;
    logic [DW-1:0] wdata_o, hi_o, lo_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          misalign_o;
`endif

    mem_lsu #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .memop_i(memop_i),
        .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .flush_i(flush_i),
        .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stall_req_o(stall_req_o), .bus_err_o(bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
       ,.misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic        flush;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        exp_wreg;
        logic        exp_whilo;
    } alu_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic        exp_wreg;
        logic [31:0] exp_wdata;
        int          exp_stalls;
        logic        exp_mis;
    } mem_vec_t;

    alu_vec_t av[5];
    mem_vec_t mv[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_i = 1'b0; memop_i = MEMOP_NONE; mem_addr_i = '0; store_data_i = '0;
        flush_i = 1'b0; wreg_i = 1'b0; wd_i = '0; wdata_i = '0;
        whilo_i = 1'b0; hi_i = '0; lo_i = '0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    endtask

    task automatic drive_alu(input logic [4:0] wd, input logic [31:0] wd_data);
        drive_idle();
        valid_i = 1'b1; wreg_i = 1'b1; wd_i = wd; wdata_i = wd_data;
    endtask

    task automatic drive_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
        drive_idle();
        valid_i = 1'b1; memop_i = op; mem_addr_i = addr; store_data_i = sd;
        wreg_i = 1'b1; wd_i = 5'd9; wdata_i = 32'h5555_5555;
    endtask

    task automatic run_mem(input mem_vec_t v, input int idx);
        int  stalls   = 0;
        bit  granted  = 1'b0;
        bit  done     = 1'b0;
        bit  saw_req  = 1'b0;
        drive_mem(v.op, v.addr, v.sdata);
        whilo_i = 1'b1; hi_i = 32'hAAAA_0000 + idx; lo_i = 32'h0000_BBBB;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            dbus_rvalid_i = granted && (v.op <= MEMOP_LW);
            dbus_rdata_i  = v.rdata;
            granted = 1'b0;
            if (c == 0) begin
                chk($sformatf("entry_wreg[%0d]", idx), wreg_o, 1'b0);
                chk($sformatf("entry_stall[%0d]", idx), stall_req_o, 1'b1);
            end
            if (dbus_req_o) begin
                saw_req = 1'b1;
                chk($sformatf("bus_addr[%0d]", idx), dbus_addr_o, v.exp_addr);
                chk($sformatf("bus_be[%0d]", idx), dbus_be_o, v.exp_be);
                chk($sformatf("bus_wdata[%0d]", idx), dbus_wdata_o, v.exp_bwdata);
                chk($sformatf("bus_we[%0d]", idx), dbus_we_o, v.op >= MEMOP_SB);
                dbus_gnt_i = 1'b1;
                granted    = 1'b1;
            end
            if (stall_req_o) begin
                stalls++;
            end else begin
                done = 1'b1;
                chk($sformatf("done_wreg[%0d]", idx), wreg_o, v.exp_wreg);
                if (v.exp_wreg) chk($sformatf("done_wdata[%0d]", idx), wdata_o, v.exp_wdata);
                chk($sformatf("done_whilo[%0d]", idx), whilo_o, 1'b1);
                chk($sformatf("done_hi[%0d]", idx), hi_o, 32'hAAAA_0000 + idx);
`ifdef MEM_MISALIGN_TRAP_EN
                chk($sformatf("done_mis[%0d]", idx), misalign_o, v.exp_mis);
`endif
            end
            step();
            dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        end
        chk($sformatf("completed[%0d]", idx), done, 1'b1);
        chk($sformatf("stalls[%0d]", idx), stalls, v.exp_stalls);
        chk($sformatf("req_seen[%0d]", idx), saw_req, v.exp_req);
        drive_idle();
    endtask

    initial begin
        int  stalls;
        bit  done;

        av[0] = '{1'b1, MEMOP_NONE, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
        av[1] = '{1'b0, MEMOP_LW,   1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 32'h11, 32'h22, 1'b1, 1'b1};
        av[2] = '{1'b1, MEMOP_LB,   1'b1, 1'b1, 5'd4, 32'h0000_0044, 1'b1, 32'h55, 32'h66, 1'b0, 1'b0};
        av[3] = '{1'b1, MEMOP_NONE, 1'b1, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 32'h33, 32'h44, 1'b0, 1'b0};
        av[4] = '{1'b1, MEMOP_NONE, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h89AB_CDEF, 32'h0123_4567, 1'b0, 1'b1};

        mv[0] = '{MEMOP_SB,  32'h1003, 32'h0000_00AB, 32'h0,         1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0,         2, 1'b0};
        mv[1] = '{MEMOP_SH,  32'h2002, 32'h1234_BEEF, 32'h0,         1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0,         2, 1'b0};
        mv[2] = '{MEMOP_SW,  32'h2004, 32'hCAFE_F00D, 32'h0,         1'b1, 32'h2004, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,         2, 1'b0};
        mv[3] = '{MEMOP_LB,  32'h2001, 32'h0,         32'h0000_8000, 1'b1, 32'h2000, 4'b0010, 32'h0,         1'b1, 32'hFFFF_FF80, 3, 1'b0};
        mv[4] = '{MEMOP_LBU, 32'h2001, 32'h0,         32'h0000_8000, 1'b1, 32'h2000, 4'b0010, 32'h0,         1'b1, 32'h0000_0080, 3, 1'b0};
        mv[5] = '{MEMOP_LH,  32'h2002, 32'h0,         32'h8001_0000, 1'b1, 32'h2000, 4'b1100, 32'h0,         1'b1, 32'hFFFF_8001, 3, 1'b0};
        mv[6] = '{MEMOP_LHU, 32'h2002, 32'h0,         32'h8001_0000, 1'b1, 32'h2000, 4'b1100, 32'h0,         1'b1, 32'h0000_8001, 3, 1'b0};
        mv[7] = '{MEMOP_LW,  32'h2008, 32'h0,         32'h8765_4321, 1'b1, 32'h2008, 4'b1111, 32'h0,         1'b1, 32'h8765_4321, 3, 1'b0};
        mv[8] = '{MEMOP_LB,  32'h2003, 32'h0,         32'h7F00_0000, 1'b1, 32'h2000, 4'b1000, 32'h0,         1'b1, 32'h0000_007F, 3, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
        mv[9] = '{MEMOP_LH,  32'h3001, 32'h0,         32'h0000_FFFE, 1'b0, 32'h0,    4'b0000, 32'h0,         1'b0, 32'h0,         1, 1'b1};
`else
        mv[9] = '{MEMOP_LH,  32'h3001, 32'h0,         32'h0000_FFFE, 1'b1, 32'h3000, 4'b0011, 32'h0,         1'b1, 32'hFFFF_FFFE, 3, 1'b0};
`endif

        // Reset: outputs held at zero even with a live ALU op on the inputs.
        rst = 1'b1;
        drive_alu(5'd5, 32'h1234);
        step();
        @(negedge clk);
        chk("rst_wreg", wreg_o, 1'b0);
        chk("rst_stall", stall_req_o, 1'b0);
        chk("rst_req", dbus_req_o, 1'b0);
        step();
        rst = 1'b0;
        drive_idle();

        foreach (av[i]) begin
            drive_idle();
            valid_i = av[i].valid; memop_i = av[i].op; flush_i = av[i].flush;
            wreg_i = av[i].wreg; wd_i = av[i].wd; wdata_i = av[i].wdata;
            whilo_i = av[i].whilo; hi_i = av[i].hi; lo_i = av[i].lo;
            mem_addr_i = 32'h2000;
            @(negedge clk);
            chk($sformatf("alu_wreg[%0d]", i), wreg_o, av[i].exp_wreg);
            chk($sformatf("alu_whilo[%0d]", i), whilo_o, av[i].exp_whilo);
            chk($sformatf("alu_stall[%0d]", i), stall_req_o, 1'b0);
            chk($sformatf("alu_req[%0d]", i), dbus_req_o, 1'b0);
            if (av[i].exp_wreg) begin
                chk($sformatf("alu_wd[%0d]", i), wd_o, av[i].wd);
                chk($sformatf("alu_wdata[%0d]", i), wdata_o, av[i].wdata);
            end
            if (av[i].exp_whilo) begin
                chk($sformatf("alu_hi[%0d]", i), hi_o, av[i].hi);
                chk($sformatf("alu_lo[%0d]", i), lo_o, av[i].lo);
            end
            step();
        end
        drive_idle();

        foreach (mv[i]) run_mem(mv[i], i);

        // Watchdog: LW that is never granted.
        drive_mem(MEMOP_LW, 32'h4000, 32'h0);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < MW + 20 && !done; c++) begin
            @(negedge clk);
            if (stall_req_o) begin
                stalls++;
            end else begin
                done = 1'b1;
                chk("wdog_err", bus_err_o, 1'b1);
                chk("wdog_wreg", wreg_o, 1'b0);
            end
            step();
        end
        chk("wdog_done", done, 1'b1);
        chk("wdog_stalls", stalls, MW + 1);
        // Late rvalid in IDLE alongside an ALU op.
        drive_alu(5'd5, 32'h1234);
        @(negedge clk);
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'hFFFF_FFFF;
        chk("late_err", bus_err_o, 1'b0);
        chk("late_wreg", wreg_o, 1'b1);
        chk("late_wdata", wdata_o, 32'h1234);
        chk("late_stall", stall_req_o, 1'b0);
        step();
        drive_alu(5'd6, 32'h99);
        @(negedge clk);
        chk("late_idle_stall", stall_req_o, 1'b0);
        chk("late_idle_req", dbus_req_o, 1'b0);
        step();

        // Flush in RESP, rvalid two cycles later.
        drive_mem(MEMOP_LW, 32'h2008, 32'h0);
        @(negedge clk);
        step();
        @(negedge clk);
        chk("fr_req", dbus_req_o, 1'b1);
        dbus_gnt_i = 1'b1;
        step();
        dbus_gnt_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        chk("fr_resp_wreg", wreg_o, 1'b0);
        step();
        drive_idle();
        @(negedge clk);
        chk("fr_drain_wreg", wreg_o, 1'b0);
        step();
        @(negedge clk);
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'h1111_1111;
        chk("fr_drain2_wreg", wreg_o, 1'b0);
        step();
        drive_alu(5'd6, 32'hABCD);
        @(negedge clk);
        chk("fr_next_stall", stall_req_o, 1'b0);
        chk("fr_next_wreg", wreg_o, 1'b1);
        chk("fr_next_wdata", wdata_o, 32'hABCD);
        step();
        drive_idle();

        // Flush in REQ before grant drops the request.
        drive_mem(MEMOP_LW, 32'h2008, 32'h0);
        @(negedge clk);
        step();
        flush_i = 1'b1;
        @(negedge clk);
        chk("fq_req", dbus_req_o, 1'b1);
        step();
        drive_alu(5'd8, 32'h4242);
        @(negedge clk);
        chk("fq_stall", stall_req_o, 1'b0);
        chk("fq_req_after", dbus_req_o, 1'b0);
        chk("fq_wreg", wreg_o, 1'b1);
        step();
        drive_idle();

        // Grant and flush together on a store: completes, no writeback.
        drive_mem(MEMOP_SW, 32'h2000, 32'h1357_9BDF);
        whilo_i = 1'b1; hi_i = 32'h1; lo_i = 32'h2;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("gf_req", dbus_req_o, 1'b1);
        dbus_gnt_i = 1'b1;
        flush_i    = 1'b1;
        step();
        dbus_gnt_i = 1'b0;
        flush_i    = 1'b0;
        @(negedge clk);
        chk("gf_done_stall", stall_req_o, 1'b0);
        chk("gf_done_whilo", whilo_o, 1'b0);
        step();
        drive_idle();
        @(negedge clk);
        chk("gf_idle_req", dbus_req_o, 1'b0);
        step();

        // Reset mid-access.
        drive_mem(MEMOP_LW, 32'h2008, 32'h0);
        @(negedge clk);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rm_req", dbus_req_o, 1'b0);
        step();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("rm_stall", stall_req_o, 1'b0);
        chk("rm_req_after", dbus_req_o, 1'b0);
        chk("rm_err", bus_err_o, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
